frame_cmd_scheduler: RTL and testbench

FRAME_CMD_SCHEDULER -- requirements
Module: frame_cmd_scheduler

---
 rtl/frame_cmd_scheduler.sv | 171 +++++++++++++++++
 tb/tb_frame_cmd_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_cmd_scheduler.sv
// frame_cmd_scheduler
//   Buffers display commands from an Avalon host in a FIFO and broadcasts
//   them, one per cycle, to every display sub-component. Each forwarded word
//   has its pp_selc bit (bit 13) replaced by back_sel, so the host never has
//   to track which buffer is the back buffer. An end-of-frame marker
//   (info == 4'b1110) stops draining until the next vertical blank. At that
//   point a single swap word (info == 4'b1111) is broadcast and back_sel
//   flips.
//
// Ports
//   clk             in   system clock (single domain)
//   reset           in   synchronous, active-low reset
//   host_writedata  in   [31:0] command word
//                        {sub_comp[31:26], child_comp[25:21], info[20:17],
//                         input_type[16:14], pp_selc[13], input_msg[12:0]}
//   host_write      in   push strobe, one word per asserted cycle
//   hcount, vcount  in   [9:0] VGA raster position
//   host_ready      out  FIFO can accept a word (combinational from count)
//   writedata       out  [31:0] registered broadcast command word
//   back_sel        out  buffer currently being drawn into
//   frame_done      out  one-cycle pulse while the swap word is driven
//   fifo_count      out  [$clog2(DEPTH):0] FIFO occupancy
//   overflow        out  sticky: a push was dropped because the FIFO was full
module frame_cmd_scheduler #(
  parameter int         DEPTH       = 16,
  parameter logic [9:0] VBLANK_LINE = 10'd480
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              host_writedata,
  input  logic                     host_write,
  input  logic [9:0]               hcount,
  input  logic [9:0]               vcount,
  output logic                     host_ready,
  output logic [31:0]              writedata,
  output logic                     back_sel,
  output logic                     frame_done,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [3:0] INFO_EOF  = 4'b1110;
  localparam logic [3:0] INFO_SWAP = 4'b1111;

  typedef enum logic [1:0] {
    DRAIN    = 2'd0,
    WAIT_VBL = 2'd1,
    SWAP     = 2'd2
  } state_t;

  // Forwarded command: everything from the host except the buffer select.
  function automatic logic [31:0] stamp_buffer(input logic [31:0] word,
                                               input logic        sel);
    return {word[31:14], sel, word[12:0]};
  endfunction

  // Swap word carries the buffer just finished so sub-components show it
  // and start clearing the other one.
  function automatic logic [31:0] swap_word(input logic sel);
    return {6'd0, 5'd0, INFO_SWAP, 3'd0, sel, 13'd0};
  endfunction

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  state_t        state_q,  state_d;
  logic [31:0]   writedata_q,  writedata_d;
  logic          back_sel_q,   back_sel_d;
  logic          frame_done_q, frame_done_d;
  logic          overflow_q,   overflow_d;

  logic          push;
  logic          pop;
  logic [31:0]   head;
  logic          fifo_empty;
  logic          vblank_hit;

  // Readiness comes from the registered count only, so a pop in the same
  // cycle never makes room for a push.
  assign host_ready = (count_q != CW'(DEPTH));
  assign push       = host_write && host_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign vblank_hit = (vcount == VBLANK_LINE) && (hcount == 10'd0);

  always_comb begin
    state_d      = state_q;
    writedata_d  = 32'd0;
    frame_done_d = 1'b0;
    back_sel_d   = back_sel_q;
    pop          = 1'b0;

    case (state_q)
      DRAIN: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head[20:17] == INFO_EOF) begin
            // Marker is consumed, never broadcast.
            state_d = WAIT_VBL;
          end else begin
            writedata_d = stamp_buffer(head, back_sel_q);
          end
        end
      end
      WAIT_VBL: begin
        if (vblank_hit) begin
          state_d      = SWAP;
          writedata_d  = swap_word(back_sel_q);
          frame_done_d = 1'b1;
        end
      end
      SWAP: begin
        back_sel_d = ~back_sel_q;
        state_d    = DRAIN;
      end
      default: begin
        state_d = DRAIN;
      end
    endcase

    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q | (host_write & ~host_ready);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= DRAIN;
      writedata_q  <= 32'd0;
      back_sel_q   <= 1'b1;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      writedata_q  <= writedata_d;
      back_sel_q   <= back_sel_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset; emptying the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem_q[wr_ptr_q] <= host_writedata;
    end
  end

  assign writedata  = writedata_q;
  assign back_sel   = back_sel_q;
  assign frame_done = frame_done_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_frame_cmd_scheduler.sv
// Directed testbench for frame_cmd_scheduler (DEPTH=16, VBLANK_LINE=480).
module tb_frame_cmd_scheduler;

  logic        clk;
  logic        reset;
  logic [31:0] host_writedata;
  logic        host_write;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        host_ready;
  logic [31:0] writedata;
  logic        back_sel;
  logic        frame_done;
  logic [4:0]  fifo_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  frame_cmd_scheduler #(.DEPTH(16), .VBLANK_LINE(10'd480)) dut (
    .clk            (clk),
    .reset          (reset),
    .host_writedata (host_writedata),
    .host_write     (host_write),
    .hcount         (hcount),
    .vcount         (vcount),
    .host_ready     (host_ready),
    .writedata      (writedata),
    .back_sel       (back_sel),
    .frame_done     (frame_done),
    .fifo_count     (fifo_count),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    host_writedata = w;
    host_write     = 1'b1;
    tick();
    host_write     = 1'b0;
  endtask

  // Exactly one edge at the vblank position.
  task automatic vblank();
    vcount = 10'd480;
    hcount = 10'd0;
    tick();
    vcount = 10'd100;
    hcount = 10'd5;
  endtask

  initial begin
    reset          = 1'b0;
    host_write     = 1'b0;
    host_writedata = 32'd0;
    hcount         = 10'd5;
    vcount         = 10'd100;
    tick();
    tick();

    // Reset state
    chk("rst_writedata",  writedata,  32'd0);
    chk("rst_back_sel",   back_sel,   1'b1);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_overflow",   overflow,   1'b0);
    chk("rst_count",      fifo_count, 5'd0);
    chk("rst_ready",      host_ready, 1'b1);
    reset = 1'b1;
    tick();

    // Single word: pp_selc stamped with back_sel=1, two edges after push
    push(32'h3C02_C123);
    chk("one_count_after_push", fifo_count, 5'd1);
    chk("one_wd_not_yet", writedata, 32'd0);
    tick();
    chk("one_writedata", writedata, 32'h3C02_E123);
    chk("one_count_after_pop", fifo_count, 5'd0);
    tick();
    chk("one_idle", writedata, 32'd0);

    // Three commands then a marker, pushed back-to-back
    host_write = 1'b1;
    host_writedata = 32'h1111_0000; tick();
    chk("stream_count1", fifo_count, 5'd1);
    host_writedata = 32'h2222_2000; tick();
    chk("stream_w0", writedata, 32'h1111_2000);
    chk("stream_count_pushpop", fifo_count, 5'd1);
    host_writedata = 32'hFFFF_DFFF; tick();
    chk("stream_w1", writedata, 32'h2222_2000);
    host_writedata = 32'h001C_0000; tick();
    chk("stream_w2", writedata, 32'hFFFF_FFFF);
    chk("stream_count_marker", fifo_count, 5'd1);
    host_write = 1'b0;
    tick();
    chk("marker_not_fwd", writedata, 32'd0);
    chk("marker_popped", fifo_count, 5'd0);
    hcount = 10'd0; vcount = 10'd100; tick();
    chk("wrong_line_no_swap", frame_done, 1'b0);
    hcount = 10'd7; vcount = 10'd480; tick();
    chk("wrong_col_no_swap", frame_done, 1'b0);
    chk("wait_wd_zero", writedata, 32'd0);
    vblank();
    chk("swap_word", writedata, 32'h001E_2000);
    chk("swap_pulse", frame_done, 1'b1);
    chk("swap_bsel_old", back_sel, 1'b1);
    tick();
    chk("swap_pulse_end", frame_done, 1'b0);
    chk("swap_bsel_new", back_sel, 1'b0);
    chk("swap_wd_after", writedata, 32'd0);

    // Two markers back-to-back: one swap per frame, back_sel 1->0->1
    reset = 1'b0; tick(); reset = 1'b1;
    chk("rst2_bsel", back_sel, 1'b1);
    host_write = 1'b1;
    host_writedata = 32'h001C_0000; tick();
    tick();
    host_write = 1'b0;
    chk("m2_one_left", fifo_count, 5'd1);
    tick(); tick();
    chk("m2_held_in_wait", fifo_count, 5'd1);
    vblank();
    chk("m2_swap1_word", writedata, 32'h001E_2000);
    chk("m2_swap1_pulse", frame_done, 1'b1);
    tick();
    chk("m2_bsel0", back_sel, 1'b0);
    tick();
    chk("m2_second_popped", fifo_count, 5'd0);
    chk("m2_no_swap_yet", frame_done, 1'b0);
    tick();
    vblank();
    chk("m2_swap2_word", writedata, 32'h001E_0000);
    chk("m2_swap2_pulse", frame_done, 1'b1);
    tick();
    chk("m2_bsel1", back_sel, 1'b1);
    tick();
    vblank();
    chk("no_marker_no_swap", frame_done, 1'b0);
    chk("no_marker_wd", writedata, 32'd0);

    // Fill while waiting for vblank, overflow, then drain in order
    reset = 1'b0; tick(); reset = 1'b1;
    push(32'h001C_0000);
    tick();
    for (int i = 0; i < 16; i++) begin
      host_writedata = 32'hA000_0000 + 32'(i);
      host_write = 1'b1;
      tick();
    end
    chk("full_count", fifo_count, 5'd16);
    chk("full_not_ready", host_ready, 1'b0);
    chk("full_no_ovf_yet", overflow, 1'b0);
    host_writedata = 32'hBAD0_0000; tick();
    host_write = 1'b0;
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_count_held", fifo_count, 5'd16);
    vblank();
    chk("full_swap_word", writedata, 32'h001E_2000);
    tick();
    host_writedata = 32'hDEAD_0000; host_write = 1'b1;
    tick();
    host_write = 1'b0;
    chk("pop_no_room", fifo_count, 5'd15);
    chk("drain_0", writedata, 32'hA000_0000);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("drain_order", writedata, 32'hA000_0000 + 32'(i));
    end
    chk("drain_empty", fifo_count, 5'd0);
    tick();
    chk("dropped_not_fwd", writedata, 32'd0);
    chk("ovf_sticky", overflow, 1'b1);

    // Reset while waiting with 5 words queued (back_sel currently 0)
    chk("pre_rst_bsel", back_sel, 1'b0);
    push(32'h001C_0000);
    host_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_writedata = 32'h0500_0000 + 32'(i);
      tick();
    end
    chk("five_queued", fifo_count, 5'd5);
    host_writedata = 32'h0777_0000;
    reset = 1'b0;
    tick();
    host_write = 1'b0;
    reset = 1'b1;
    chk("rst_mid_count", fifo_count, 5'd0);
    chk("rst_mid_bsel", back_sel, 1'b1);
    chk("rst_mid_ovf", overflow, 1'b0);
    tick();
    vblank();
    chk("rst_mid_no_swap", frame_done, 1'b0);
    chk("rst_mid_wd", writedata, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
